data_memory_responder: RTL and testbench

- Memory-side responder for the integer datapath's load/store interface.
- Accepts a word access request:
  - address from the datapath ALU output register;
  - store data from the datapath D output.
- Performs the access on a byte-addressed, big-endian internal memory after a fixed wait latency.
- Returns load data for the datapath DY input with a one-cycle ready pulse. Flags misaligned accesses.

---
 rtl/data_memory_responder.sv | 138 +++++++++++++
 tb/tb_data_memory_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Load/store responder for the integer datapath: a big-endian byte-addressed memory
// that completes each word access after a fixed wait and flags misaligned or ambiguous requests.
module data_memory_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        dm_cs,
    input  logic        dm_wr,
    input  logic        dm_rd,
    input  logic [31:0] Address,
    input  logic [31:0] D_In,
    output logic [31:0] D_Out,
    output logic        ready,
    output logic        addr_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is taken on a rising edge where dm_cs & (dm_wr | dm_rd) and the
    // responder is not waiting; ready is high for exactly one cycle when the access completes.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0]        LAT      = 4'(LATENCY);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [31:0]         dout_q, dout_d;
    logic                accept, complete, mem_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [31:0]         acc_data;
    logic                acc_wr, acc_err, in_err;
    logic [7:0]          mem_q [2**ADDR_W];
    logic                unused_addr;

    assign unused_addr = ^Address[31:ADDR_W];
    assign in_err      = (Address[1:0] != 2'b00) || (dm_wr && dm_rd);
    assign accept      = (state_q != S_WAIT) && dm_cs && (dm_wr || dm_rd);

    // With zero latency the access completes on the accepting edge, so it must use the live inputs.
    assign acc_addr = (state_q == S_WAIT) ? addr_q : Address[ADDR_W-1:0];
    assign acc_data = (state_q == S_WAIT) ? data_q : D_In;
    assign acc_wr   = (state_q == S_WAIT) ? wr_q   : dm_wr;
    assign acc_err  = (state_q == S_WAIT) ? err_q  : in_err;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_d     = wr_q;
        err_d    = err_q;
        complete = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    addr_d = Address[ADDR_W-1:0];
                    data_d = D_In;
                    wr_d   = dm_wr;
                    err_d  = in_err;
                    cnt_d  = LAT;
                    if (LAT == 4'd0) begin
                        state_d  = S_DONE;
                        complete = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d  = S_DONE;
                    complete = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dout_d = dout_q;
        if (complete && !acc_wr && !acc_err) begin
            dout_d = {mem_q[acc_addr], mem_q[acc_addr + ADDR_ONE],
                      mem_q[acc_addr + 2 * ADDR_ONE], mem_q[acc_addr + 3 * ADDR_ONE]};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 32'h0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Memory contents survive reset; the RESET term blocks a zero-latency write while in reset.
    assign mem_we = complete && acc_wr && !acc_err && RESET;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[acc_addr]                <= acc_data[31:24];
            mem_q[acc_addr + ADDR_ONE]     <= acc_data[23:16];
            mem_q[acc_addr + 2 * ADDR_ONE] <= acc_data[15:8];
            mem_q[acc_addr + 3 * ADDR_ONE] <= acc_data[7:0];
        end
    end

    assign D_Out     = dout_q;
    assign ready     = (state_q == S_DONE);
    assign addr_err  = (state_q == S_DONE) && err_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: LATENCY=2 and LATENCY=0 instances share one stimulus stream
// and are checked every cycle against an edge-counting transaction model.
module tb_data_memory_responder;

  logic        CLK, RESET;
  logic        dm_cs, dm_wr, dm_rd;
  logic [31:0] Address, D_In;
  logic [31:0] d_out2, d_out0;
  logic        rdy2, rdy0, err2, err0, busy2, busy0;
  logic [1:0]  st2, st0;

  int nvec = 0;
  int nmis = 0;

  data_memory_responder #(.ADDR_W(12), .LATENCY(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .dm_cs(dm_cs), .dm_wr(dm_wr), .dm_rd(dm_rd),
    .Address(Address), .D_In(D_In), .D_Out(d_out2), .ready(rdy2),
    .addr_err(err2), .busy(busy2), .dbg_state(st2)
  );

  data_memory_responder #(.ADDR_W(12), .LATENCY(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .dm_cs(dm_cs), .dm_wr(dm_wr), .dm_rd(dm_rd),
    .Address(Address), .D_In(D_In), .D_Out(d_out0), .ready(rdy0),
    .addr_err(err0), .busy(busy0), .dbg_state(st0)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // behavioural model: index 0 -> LATENCY=2 instance, index 1 -> LATENCY=0 instance
  int          lat_m   [0:1] = '{2, 0};
  logic [7:0]  mem_m   [0:1][0:4095];
  logic        pend    [0:1] = '{0, 0};
  int          left    [0:1] = '{0, 0};
  logic [11:0] la      [0:1];
  logic [31:0] ld      [0:1];
  logic        lwr     [0:1];
  logic        lerr    [0:1];
  logic        m_busy  [0:1] = '{0, 0};
  logic        m_ready [0:1] = '{0, 0};
  logic        m_err   [0:1] = '{0, 0};
  logic [31:0] m_dout  [0:1] = '{32'h0, 32'h0};

  always @(posedge CLK or negedge RESET) begin
    for (int k = 0; k < 2; k++) begin
      if (!RESET) begin
        pend[k] = 1'b0; m_busy[k] = 1'b0; m_ready[k] = 1'b0; m_err[k] = 1'b0;
        m_dout[k] = 32'h0;
      end else begin
        m_ready[k] = 1'b0;
        m_err[k]   = 1'b0;
        if (!m_busy[k] && dm_cs && (dm_wr || dm_rd)) begin
          la[k]   = Address[11:0];
          ld[k]   = D_In;
          lwr[k]  = dm_wr;
          lerr[k] = (Address[1:0] != 2'b00) || (dm_wr && dm_rd);
          pend[k] = 1'b1;
          left[k] = lat_m[k];
        end else if (pend[k]) begin
          left[k] = left[k] - 1;
        end
        m_busy[k] = pend[k];
        if (pend[k] && left[k] == 0) begin
          pend[k]    = 1'b0;
          m_ready[k] = 1'b1;
          m_err[k]   = lerr[k];
          if (!lerr[k]) begin
            if (lwr[k]) begin
              mem_m[k][la[k]]         = ld[k][31:24];
              mem_m[k][la[k] + 12'd1] = ld[k][23:16];
              mem_m[k][la[k] + 12'd2] = ld[k][15:8];
              mem_m[k][la[k] + 12'd3] = ld[k][7:0];
            end else begin
              m_dout[k] = {mem_m[k][la[k]], mem_m[k][la[k] + 12'd1],
                           mem_m[k][la[k] + 12'd2], mem_m[k][la[k] + 12'd3]};
            end
          end
        end
      end
    end
  end

  // scoreboard helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // per-cycle compare, away from the active edge
  always @(negedge CLK) begin
    chk("dout_l2",  d_out2,        m_dout[0]);
    chk("ready_l2", 32'(rdy2),     32'(m_ready[0]));
    chk("err_l2",   32'(err2),     32'(m_err[0]));
    chk("busy_l2",  32'(busy2),    32'(m_busy[0]));
    chk("dout_l0",  d_out0,        m_dout[1]);
    chk("ready_l0", 32'(rdy0),     32'(m_ready[1]));
    chk("err_l0",   32'(err0),     32'(m_err[1]));
    chk("busy_l0",  32'(busy0),    32'(m_busy[1]));
  end

  // driver: present a request for one edge, scramble inputs while busy, wait for completion
  int   lat2_r, lat0_r, b0cnt_r;
  logic err_r;

  task automatic do_req(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data);
    dm_cs = 1'b1; dm_wr = wr; dm_rd = rd; Address = addr; D_In = data;
    @(posedge CLK);
    @(negedge CLK);
    dm_cs = 1'b0; dm_wr = 1'($urandom_range(0, 1)); dm_rd = 1'($urandom_range(0, 1));
    Address = $urandom; D_In = $urandom;
    lat2_r = 0; lat0_r = 0; b0cnt_r = 0; err_r = 1'b0;
    for (int n = 1; n <= 20 && lat2_r == 0; n++) begin
      if (rdy0 && lat0_r == 0) lat0_r = n;
      if (busy0) b0cnt_r++;
      if (rdy2) begin
        lat2_r = n;
        err_r  = err2;
      end
      if (lat2_r == 0) @(negedge CLK);
    end
    if (lat2_r == 0) begin
      nvec++;
      nmis++;
      $display("FAIL timeout: ready not seen within 20 cycles for addr %h", addr);
    end
    @(negedge CLK);
  endtask

  logic saw_ready;

  initial begin
    RESET = 1'b0; dm_cs = 1'b0; dm_wr = 1'b0; dm_rd = 1'b0; Address = 32'h0; D_In = 32'h0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (10) @(negedge CLK);
    chk("idle_dout", d_out2, 32'h0);
    chk("idle_busy", 32'(busy2), 32'h0);

    // store/load round trip and latency
    do_req(1'b1, 1'b0, 32'h010, 32'hDEADBEEF);
    chk("wr_latency_l2", 32'(lat2_r), 32'd3);
    chk("wr_latency_l0", 32'(lat0_r), 32'd1);
    chk("busy_cycles_l0", 32'(b0cnt_r), 32'd1);
    do_req(1'b0, 1'b1, 32'h010, 32'h0);
    chk("rd_010", d_out2, 32'hDEADBEEF);
    chk("rd_010_err", 32'(err_r), 32'h0);
    do_req(1'b0, 1'b1, 32'h011, 32'h0);
    chk("rd_011_err", 32'(err_r), 32'h1);
    chk("rd_011_hold", d_out2, 32'hDEADBEEF);

    // byte order
    do_req(1'b1, 1'b0, 32'h020, 32'h11223344);
    do_req(1'b0, 1'b1, 32'h020, 32'h0);
    chk("rd_020", d_out0, 32'h11223344);
    chk("mem_020", 32'(u_dut.mem_q[12'h020]), 32'h11);
    chk("mem_023", 32'(u_dut.mem_q[12'h023]), 32'h44);

    // misaligned store leaves neighbours alone
    do_req(1'b1, 1'b0, 32'h030, 32'h01020304);
    do_req(1'b1, 1'b0, 32'h034, 32'h05060708);
    do_req(1'b1, 1'b0, 32'h032, 32'hCAFEF00D);
    chk("wr_032_err", 32'(err_r), 32'h1);
    do_req(1'b0, 1'b1, 32'h030, 32'h0);
    chk("rd_030", d_out2, 32'h01020304);
    do_req(1'b0, 1'b1, 32'h034, 32'h0);
    chk("rd_034", d_out2, 32'h05060708);

    // illegal op and address wrap
    do_req(1'b1, 1'b0, 32'h040, 32'h55667788);
    do_req(1'b1, 1'b1, 32'h040, 32'h99999999);
    chk("both_op_err", 32'(err_r), 32'h1);
    do_req(1'b0, 1'b1, 32'h040, 32'h0);
    chk("rd_040", d_out2, 32'h55667788);
    do_req(1'b1, 1'b0, 32'hFFFF_F044, 32'hA5A5A5A5);
    do_req(1'b0, 1'b1, 32'h044, 32'h0);
    chk("rd_044_wrap", d_out2, 32'hA5A5A5A5);
    do_req(1'b1, 1'b0, 32'h0FFC, 32'h0A0B0C0D);
    do_req(1'b0, 1'b1, 32'h0FFC, 32'h0);
    chk("rd_top_word", d_out2, 32'h0A0B0C0D);

    // reset during WAIT aborts the LATENCY=2 write; the LATENCY=0 one already completed
    do_req(1'b1, 1'b0, 32'h050, 32'h0BADF00D);
    dm_cs = 1'b1; dm_wr = 1'b1; dm_rd = 1'b0; Address = 32'h050; D_In = 32'h12345678;
    @(posedge CLK);
    @(negedge CLK);
    dm_cs = 1'b0; dm_wr = 1'b0;
    #2 RESET = 1'b0;
    saw_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge CLK);
      if (rdy2) saw_ready = 1'b1;
    end
    chk("abort_no_ready", 32'(saw_ready), 32'h0);
    chk("abort_dout_cleared", d_out2, 32'h0);
    do_req(1'b0, 1'b1, 32'h050, 32'h0);
    chk("rd_050_l2", d_out2, 32'h0BADF00D);
    chk("rd_050_l0", d_out0, 32'h12345678);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
